// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between the PC unit and the decoder.
// Misses stall fetch and refill a whole line from memory, one beat per ack.
module inst_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  ic_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data
);

    localparam int W = $clog2(LINE_WORDS);
    localparam int I = $clog2(NUM_LINES);
    localparam int T = ADDR_WIDTH - W - I - 2;
    localparam logic [W-1:0] LAST = W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t state, state_nx;

    logic [NUM_LINES-1:0]  valid;
    logic [T-1:0]          tags [NUM_LINES];
    logic [DATA_WIDTH-1:0] data [NUM_LINES][LINE_WORDS];

    logic [ADDR_WIDTH-1:0] req_pc;
    logic [W-1:0]          cnt;
    logic                  flush_seen;

    logic [W-1:0] pc_off, req_off;
    logic [I-1:0] pc_idx, req_idx;
    logic [T-1:0] pc_tag, req_tag;
    logic         hit, lookup, last_beat;
    logic         unused;

    assign pc_off  = pc[W+1:2];
    assign pc_idx  = pc[W+I+1:W+2];
    assign pc_tag  = pc[ADDR_WIDTH-1:W+I+2];
    assign req_off = req_pc[W+1:2];
    assign req_idx = req_pc[W+I+1:W+2];
    assign req_tag = req_pc[ADDR_WIDTH-1:W+I+2];
    assign unused  = ^{pc[1:0], req_pc[1:0]};

    assign hit       = valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign lookup    = (state == IDLE) && ce && !flush;
    assign last_beat = (state == REFILL) && mem_ack && (cnt == LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (lookup && !hit) state_nx = REFILL;
            REFILL:  if (last_beat) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            ic_stall   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            cnt        <= '0;
            req_pc     <= '0;
            flush_seen <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    inst_valid <= 1'b0;
                    if (lookup) begin
                        req_pc <= pc;
                        if (hit) begin
                            inst       <= data[pc_idx][pc_off];
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                        end else begin
                            ic_stall <= 1'b1;
                            mem_req  <= 1'b1;
                            mem_addr <= {pc[ADDR_WIDTH-1:W+2], {(W+2){1'b0}}};
                            cnt      <= '0;
                        end
                    end
                end
                REFILL: begin
                    // A flush only kills the response; the line still fills.
                    if (flush) flush_seen <= 1'b1;
                    if (mem_ack) cnt <= cnt + 1'b1;
                    if (last_beat) begin
                        valid[req_idx] <= 1'b1;
                        mem_req        <= 1'b0;
                    end
                end
                RESP: begin
                    if (flush_seen || flush) begin
                        inst_valid <= 1'b0;
                    end else begin
                        inst       <= data[req_idx][req_off];
                        inst_pc    <= req_pc;
                        inst_valid <= 1'b1;
                    end
                    ic_stall   <= 1'b0;
                    flush_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Array contents need no reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (rst && state == REFILL && mem_ack) begin
            data[req_idx][cnt] <= mem_data;
            if (cnt == LAST) tags[req_idx] <= req_tag;
        end
    end

endmodule
